// File: rtl/storeq_ring.sv
// In-order circular store queue: dispatch-time allocation, execute-time capture,
// commit-to-senior, in-order drain, age-based nuke and single-port store-to-load forwarding.
module storeq_ring #(
    parameter int NUM_ENTRIES = 16,
    parameter int ROBID_W     = 6,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int CMT_WIDTH   = 2,
    localparam int ID_W       = $clog2(NUM_ENTRIES),
    localparam int CC_W       = $clog2(CMT_WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ROBID_W-1:0] oldest_robid,
    input  logic               alloc_valid,
    input  logic [ROBID_W-1:0] alloc_robid,
    output logic               alloc_ready,
    output logic [ID_W-1:0]    alloc_stqid,
    input  logic               exec_valid,
    input  logic [ID_W-1:0]    exec_stqid,
    input  logic [ADDR_W-1:0]  exec_addr,
    input  logic [DATA_W-1:0]  exec_data,
    input  logic [1:0]         exec_size,
    input  logic [CC_W-1:0]    commit_cnt,
    input  logic               nuke_valid,
    input  logic [ROBID_W-1:0] nuke_robid,
    output logic               pipe_req,
    output logic [ID_W-1:0]    pipe_stqid,
    output logic [ADDR_W-1:0]  pipe_addr,
    output logic [DATA_W-1:0]  pipe_data,
    output logic [1:0]         pipe_size,
    input  logic               pipe_gnt,
    input  logic               ld_valid,
    input  logic [ROBID_W-1:0] ld_robid,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  logic [1:0]         ld_size,
    output logic               fwd_hit,
    output logic [DATA_W-1:0]  fwd_data,
    output logic               fwd_stall,
    output logic [ID_W:0]      count
);

    localparam int PTR_W = ID_W + 1;

    logic [PTR_W-1:0]       head_ptr, cmt_ptr, tail_ptr;
    logic [ID_W-1:0]        head_idx, tail_idx;
    logic [PTR_W-1:0]       occ;
    logic                   q_full;

    logic [NUM_ENTRIES-1:0] ent_valid, ent_exec, ent_senior;
    logic [ROBID_W-1:0]     ent_robid [NUM_ENTRIES];
    logic [ADDR_W-1:0]      ent_addr  [NUM_ENTRIES];
    logic [DATA_W-1:0]      ent_data  [NUM_ENTRIES];
    logic [1:0]             ent_size  [NUM_ENTRIES];

    logic [NUM_ENTRIES-1:0] cmt_mask, flush, fwd_decide;
    logic [ROBID_W-1:0]     nuke_age, ld_age;
    logic [ADDR_W:0]        ld_end;
    logic                   nuke_hit;
    logic [PTR_W-1:0]       nuke_tail;
    logic                   alloc_ok, exec_ok, drain_fire;
    logic                   dec_found;
    logic [ID_W-1:0]        dec_idx;

    function automatic logic [ROBID_W-1:0] rob_age(input logic [ROBID_W-1:0] r,
                                                   input logic [ROBID_W-1:0] base);
        return r - base;
    endfunction

    // Exclusive end of a byte range; one extra bit so the top of the address space cannot wrap.
    function automatic logic [ADDR_W:0] byte_end(input logic [ADDR_W-1:0] a, input logic [1:0] sz);
        return {1'b0, a} + ((ADDR_W + 1)'(1) << sz);
    endfunction

    function automatic logic [DATA_W-1:0] fwd_extract(input logic [DATA_W-1:0] d,
                                                      input logic [2:0]        ofs,
                                                      input logic [1:0]        sz);
        logic [DATA_W-1:0] sh;
        logic [DATA_W-1:0] res;
        sh = d >> {ofs, 3'b000};
        case (sz)
            2'd0:    res = {{(DATA_W - 8){1'b0}}, sh[7:0]};
            2'd1:    res = {{(DATA_W - 16){1'b0}}, sh[15:0]};
            2'd2:    res = {{(DATA_W - 32){1'b0}}, sh[31:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign head_idx    = head_ptr[ID_W-1:0];
    assign tail_idx    = tail_ptr[ID_W-1:0];
    assign q_full      = (head_idx == tail_idx) && (head_ptr[ID_W] != tail_ptr[ID_W]);
    assign occ         = tail_ptr - head_ptr;
    assign count       = occ;
    assign alloc_ready = !q_full;
    assign alloc_stqid = tail_idx;

    assign nuke_age = rob_age(nuke_robid, oldest_robid);
    assign ld_age   = rob_age(ld_robid, oldest_robid);
    assign ld_end   = byte_end(ld_addr, ld_size);

    always_comb begin
        cmt_mask = '0;
        for (int k = 0; k < CMT_WIDTH; k++) begin
            if (k < int'(commit_cnt)) cmt_mask[cmt_ptr[ID_W-1:0] + ID_W'(k)] = 1'b1;
        end
    end

    // Commit is resolved before the flush, so entries turning senior this cycle survive it.
    always_comb begin
        flush = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            flush[i] = nuke_valid && ent_valid[i] && !ent_senior[i] && !cmt_mask[i] &&
                       (rob_age(ent_robid[i], oldest_robid) >= nuke_age);
        end
    end

    always_comb begin
        nuke_hit  = 1'b0;
        nuke_tail = tail_ptr;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!nuke_hit && (PTR_W'(i) < occ) && flush[head_idx + ID_W'(i)]) begin
                nuke_hit  = 1'b1;
                nuke_tail = head_ptr + PTR_W'(i);
            end
        end
    end

    assign alloc_ok = alloc_valid && !q_full && !nuke_valid;
    assign exec_ok  = exec_valid && ent_valid[exec_stqid] && !ent_senior[exec_stqid] &&
                      !flush[exec_stqid];

    assign pipe_req   = ent_valid[head_idx] && ent_senior[head_idx] && ent_exec[head_idx];
    assign pipe_stqid = head_idx;
    assign pipe_addr  = ent_addr[head_idx];
    assign pipe_data  = ent_data[head_idx];
    assign pipe_size  = ent_size[head_idx];
    assign drain_fire = pipe_req && pipe_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr   <= '0;
            cmt_ptr    <= '0;
            tail_ptr   <= '0;
            ent_valid  <= '0;
            ent_exec   <= '0;
            ent_senior <= '0;
        end else begin
            cmt_ptr <= cmt_ptr + PTR_W'(commit_cnt);
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (cmt_mask[i]) ent_senior[i] <= 1'b1;
                if (flush[i])    ent_valid[i]  <= 1'b0;
            end
            if (exec_ok) ent_exec[exec_stqid] <= 1'b1;
            if (alloc_ok) begin
                ent_valid[tail_idx]  <= 1'b1;
                ent_exec[tail_idx]   <= 1'b0;
                ent_senior[tail_idx] <= 1'b0;
                tail_ptr             <= tail_ptr + PTR_W'(1);
            end else if (nuke_hit) begin
                tail_ptr <= nuke_tail;
            end
            if (drain_fire) begin
                ent_valid[head_idx]  <= 1'b0;
                ent_senior[head_idx] <= 1'b0;
                head_ptr             <= head_ptr + PTR_W'(1);
            end
        end
    end

    // Payload storage carries no reset; the valid flags qualify every read.
    always_ff @(posedge clk) begin
        if (alloc_ok) ent_robid[tail_idx] <= alloc_robid;
        if (exec_ok) begin
            ent_addr[exec_stqid] <= exec_addr;
            ent_data[exec_stqid] <= exec_data;
            ent_size[exec_stqid] <= exec_size;
        end
    end

    always_comb begin
        fwd_decide = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            fwd_decide[i] = ent_valid[i] &&
                            (ent_senior[i] || (rob_age(ent_robid[i], oldest_robid) < ld_age)) &&
                            (!ent_exec[i] ||
                             (({1'b0, ent_addr[i]} < ld_end) &&
                              ({1'b0, ld_addr} < byte_end(ent_addr[i], ent_size[i]))));
        end
    end

    // Walk oldest to youngest so the last deciding entry seen is the youngest one.
    always_comb begin
        dec_found = 1'b0;
        dec_idx   = head_idx;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (fwd_decide[head_idx + ID_W'(i)]) begin
                dec_found = 1'b1;
                dec_idx   = head_idx + ID_W'(i);
            end
        end
    end

    always_comb begin
        fwd_hit   = 1'b0;
        fwd_stall = 1'b0;
        fwd_data  = '0;
        if (ld_valid && dec_found) begin
            if (!ent_exec[dec_idx]) begin
                fwd_stall = 1'b1;
            end else if ((ent_addr[dec_idx] <= ld_addr) &&
                         (ld_end <= byte_end(ent_addr[dec_idx], ent_size[dec_idx]))) begin
                fwd_hit  = 1'b1;
                fwd_data = fwd_extract(ent_data[dec_idx], ld_addr[2:0] - ent_addr[dec_idx][2:0],
                                       ld_size);
            end else begin
                fwd_stall = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_storeq_ring.sv
// Directed bench for storeq_ring: fill/full, drain handshake, nuke recovery,
// store-to-load forwarding and pointer wrap.
module tb_storeq_ring;

    logic        clk;
    logic        reset;
    logic [5:0]  oldest_robid;
    logic        alloc_valid;
    logic [5:0]  alloc_robid;
    logic        alloc_ready;
    logic [3:0]  alloc_stqid;
    logic        exec_valid;
    logic [3:0]  exec_stqid;
    logic [63:0] exec_addr;
    logic [63:0] exec_data;
    logic [1:0]  exec_size;
    logic [1:0]  commit_cnt;
    logic        nuke_valid;
    logic [5:0]  nuke_robid;
    logic        pipe_req;
    logic [3:0]  pipe_stqid;
    logic [63:0] pipe_addr;
    logic [63:0] pipe_data;
    logic [1:0]  pipe_size;
    logic        pipe_gnt;
    logic        ld_valid;
    logic [5:0]  ld_robid;
    logic [63:0] ld_addr;
    logic [1:0]  ld_size;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic        fwd_stall;
    logic [4:0]  count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_drain;

    storeq_ring dut (
        .clk(clk), .reset(reset), .oldest_robid(oldest_robid),
        .alloc_valid(alloc_valid), .alloc_robid(alloc_robid),
        .alloc_ready(alloc_ready), .alloc_stqid(alloc_stqid),
        .exec_valid(exec_valid), .exec_stqid(exec_stqid), .exec_addr(exec_addr),
        .exec_data(exec_data), .exec_size(exec_size), .commit_cnt(commit_cnt),
        .nuke_valid(nuke_valid), .nuke_robid(nuke_robid),
        .pipe_req(pipe_req), .pipe_stqid(pipe_stqid), .pipe_addr(pipe_addr),
        .pipe_data(pipe_data), .pipe_size(pipe_size), .pipe_gnt(pipe_gnt),
        .ld_valid(ld_valid), .ld_robid(ld_robid), .ld_addr(ld_addr), .ld_size(ld_size),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        oldest_robid = '0;
        alloc_valid  = 1'b0; alloc_robid = '0;
        exec_valid   = 1'b0; exec_stqid  = '0; exec_addr = '0; exec_data = '0; exec_size = '0;
        commit_cnt   = '0;
        nuke_valid   = 1'b0; nuke_robid  = '0;
        pipe_gnt     = 1'b0;
        ld_valid     = 1'b0; ld_robid    = '0; ld_addr = '0; ld_size = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        step();
        reset = 1'b1;
    endtask

    task automatic alloc(input logic [5:0] r);
        alloc_valid = 1'b1;
        alloc_robid = r;
        step();
        alloc_valid = 1'b0;
    endtask

    task automatic exec_st(input logic [3:0] id, input logic [63:0] a, input logic [63:0] d,
                           input logic [1:0] sz);
        exec_valid = 1'b1; exec_stqid = id; exec_addr = a; exec_data = d; exec_size = sz;
        step();
        exec_valid = 1'b0;
    endtask

    task automatic load(input logic [5:0] r, input logic [63:0] a, input logic [1:0] sz);
        ld_valid = 1'b1; ld_robid = r; ld_addr = a; ld_size = sz;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        step();
        step();
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        chk("rst_alloc_stqid", 64'(alloc_stqid), 64'd0);
        chk("rst_pipe_req",    64'(pipe_req),    64'd0);
        chk("rst_fwd_hit",     64'(fwd_hit),     64'd0);
        chk("rst_fwd_stall",   64'(fwd_stall),   64'd0);
        chk("rst_count",       64'(count),       64'd0);
        reset = 1'b1;

        // Fill to full, then an ignored alloc, then flush everything.
        for (int i = 0; i < 16; i++) begin
            alloc_valid = 1'b1;
            alloc_robid = 6'(i);
            #1;
            chk("fill_stqid", 64'(alloc_stqid), 64'(i));
            step();
        end
        alloc_robid = 6'd16;
        chk("full_count", 64'(count), 64'd16);
        chk("full_ready", 64'(alloc_ready), 64'd0);
        step();
        alloc_valid = 1'b0;
        chk("full_ignored_count", 64'(count), 64'd16);
        chk("full_ignored_stqid", 64'(alloc_stqid), 64'd0);
        nuke_valid = 1'b1; nuke_robid = 6'd0;
        step();
        nuke_valid = 1'b0;
        chk("nuke_all_count", 64'(count), 64'd0);
        chk("nuke_all_ready", 64'(alloc_ready), 64'd1);

        // Drain handshake with grant held off.
        do_reset();
        alloc(6'd0); alloc(6'd1); alloc(6'd2);
        exec_st(4'd0, 64'h1000, 64'hAABB, 2'd3);
        commit_cnt = 2'd1;
        step();
        commit_cnt = 2'd0;
        for (int c = 0; c < 3; c++) begin
            chk("hold_req",  64'(pipe_req),  64'd1);
            chk("hold_addr", pipe_addr,      64'h1000);
            chk("hold_data", pipe_data,      64'hAABB);
            step();
        end
        chk("drain_stqid", 64'(pipe_stqid), 64'd0);
        pipe_gnt = 1'b1;
        step();
        pipe_gnt = 1'b0;
        chk("drain_count", 64'(count), 64'd2);
        chk("drain_head",  64'(pipe_stqid), 64'd1);
        chk("drain_req_off", 64'(pipe_req), 64'd0);
        pipe_gnt = 1'b1;
        step();
        pipe_gnt = 1'b0;
        chk("gnt_noreq_count", 64'(count), 64'd2);

        // Commit + nuke + alloc in the same cycle.
        do_reset();
        alloc(6'd4); alloc(6'd5); alloc(6'd6); alloc(6'd7); alloc(6'd8);
        exec_st(4'd0, 64'h40, 64'd4, 2'd3);
        exec_st(4'd1, 64'h48, 64'd5, 2'd3);
        commit_cnt = 2'd2; nuke_valid = 1'b1; nuke_robid = 6'd6;
        alloc_valid = 1'b1; alloc_robid = 6'd9;
        step();
        idle();
        chk("nuke_count", 64'(count), 64'd2);
        chk("nuke_tail",  64'(alloc_stqid), 64'd2);
        chk("nuke_req",   64'(pipe_req), 64'd1);
        chk("nuke_head",  64'(pipe_stqid), 64'd0);
        nuke_valid = 1'b1; nuke_robid = 6'd4;
        step();
        nuke_valid = 1'b0;
        chk("senior_kept_count", 64'(count), 64'd2);
        pipe_gnt = 1'b1;
        step();
        chk("second_req",   64'(pipe_req), 64'd1);
        chk("second_stqid", 64'(pipe_stqid), 64'd1);
        chk("second_data",  pipe_data, 64'd5);
        step();
        pipe_gnt = 1'b0;
        chk("drained_count", 64'(count), 64'd0);

        // Forwarding from a single doubleword store.
        do_reset();
        alloc(6'd1);
        exec_st(4'd0, 64'h2000, 64'h1122334455667788, 2'd3);
        load(6'd5, 64'h2003, 2'd0);
        chk("fwd_b_hit",   64'(fwd_hit), 64'd1);
        chk("fwd_b_stall", 64'(fwd_stall), 64'd0);
        chk("fwd_b_data",  fwd_data, 64'h55);
        load(6'd5, 64'h2006, 2'd1);
        chk("fwd_h_data",  fwd_data, 64'h1122);
        load(6'd0, 64'h2003, 2'd0);
        chk("fwd_older_hit",   64'(fwd_hit), 64'd0);
        chk("fwd_older_stall", 64'(fwd_stall), 64'd0);
        load(6'd5, 64'h2006, 2'd2);
        chk("fwd_cross_stall", 64'(fwd_stall), 64'd1);
        chk("fwd_cross_hit",   64'(fwd_hit), 64'd0);
        load(6'd5, 64'h2010, 2'd3);
        chk("fwd_miss_hit",   64'(fwd_hit), 64'd0);
        chk("fwd_miss_stall", 64'(fwd_stall), 64'd0);
        load(6'd5, 64'h2003, 2'd0);
        ld_valid = 1'b0;
        #1;
        chk("fwd_noload_hit",   64'(fwd_hit), 64'd0);
        chk("fwd_noload_stall", 64'(fwd_stall), 64'd0);

        // Unexecuted and partially overlapping stores, youngest-first selection.
        do_reset();
        alloc(6'd1);
        exec_st(4'd0, 64'h2004, 64'hDEADBEEF, 2'd2);
        alloc(6'd2);
        load(6'd5, 64'h2000, 2'd3);
        chk("unexec_stall", 64'(fwd_stall), 64'd1);
        chk("unexec_hit",   64'(fwd_hit), 64'd0);
        exec_st(4'd1, 64'h3000, 64'h99, 2'd3);
        load(6'd5, 64'h2000, 2'd3);
        chk("partial_stall", 64'(fwd_stall), 64'd1);
        load(6'd5, 64'h2004, 2'd2);
        chk("w_hit",  64'(fwd_hit), 64'd1);
        chk("w_data", fwd_data, 64'hDEADBEEF);
        alloc(6'd3);
        exec_st(4'd2, 64'h2004, 64'h11223344, 2'd2);
        load(6'd5, 64'h2004, 2'd2);
        chk("youngest_data", fwd_data, 64'h11223344);
        load(6'd5, 64'h2006, 2'd1);
        chk("youngest_h_data", fwd_data, 64'h1122);
        load(6'd3, 64'h2004, 2'd2);
        chk("skip_self_data", fwd_data, 64'hDEADBEEF);
        commit_cnt = 2'd1;
        step();
        commit_cnt = 2'd0;
        load(6'd0, 64'h2004, 2'd2);
        chk("senior_fwd_hit",  64'(fwd_hit), 64'd1);
        chk("senior_fwd_data", fwd_data, 64'hDEADBEEF);

        // Streaming alloc/exec/commit/drain across two pointer wraps.
        do_reset();
        exp_drain = 0;
        for (int t = 0; t < 44; t++) begin
            alloc_valid = (t < 40);
            alloc_robid = 6'(t);
            exec_valid  = (t >= 1 && t <= 40);
            exec_stqid  = 4'(t - 1);
            exec_addr   = 64'(t - 1) * 64'd8;
            exec_data   = 64'(t - 1);
            exec_size   = 2'd3;
            commit_cnt  = (t >= 2 && t <= 41) ? 2'd1 : 2'd0;
            pipe_gnt    = 1'b1;
            #1;
            if (t < 40) begin
                chk("wrap_stqid", 64'(alloc_stqid), 64'(t % 16));
                chk("wrap_ready", 64'(alloc_ready), 64'd1);
            end
            if (t >= 3 && t <= 40) chk("wrap_count", 64'(count), 64'd3);
            chk("wrap_req", 64'(pipe_req), 64'(t >= 3 && t <= 42));
            if (pipe_req) begin
                chk("wrap_drain_data",  pipe_data, 64'(exp_drain));
                chk("wrap_drain_stqid", 64'(pipe_stqid), 64'(exp_drain % 16));
                exp_drain++;
            end
            step();
        end
        idle();
        chk("wrap_total", 64'(exp_drain), 64'd40);
        chk("wrap_empty", 64'(count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
